// File: rtl/mul_seq_ctrl.sv
// Sequential shift-and-add multiplier controller for the EX stage.
// A MULT is accepted only from IDLE. It runs exactly 32 RUN cycles, with no
// early exit, and then pulses done_o for one DONE cycle. The pipeline is
// stalled from the start cycle through the last RUN cycle.
module mul_seq_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  ALUCtrl_i,
  input  logic        valid_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  localparam logic [3:0] OP_MULT = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        start;

  // The term ~rst_i keeps stall_o low while reset is held, even if a MULT sits in EX.
  assign start = (state_q == S_IDLE) & valid_i & (ALUCtrl_i == OP_MULT) &
                 ~flush_i & ~rst_i;

  // Next-state logic and datapath. Only the low 32 product bits are kept,
  // so signed and unsigned operands give the same result.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = src1_i;
          mplier_d = src2_i;
          acc_d    = 32'h0;
          cnt_d    = 5'd0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = S_DONE;
            result_d = acc_d;  // so the result is already registered in DONE
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= 32'h0;
      mplier_q <= 32'h0;
      acc_q    <= 32'h0;
      cnt_q    <= 5'd0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign stall_o  = start | (state_q == S_RUN);
  assign busy_o   = (state_q == S_RUN);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl. A table of products runs through the full
// 34-cycle handshake. Hand-written sequences cover flush, reset, back-to-back
// MULTs and non-MULT operations.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  alu;
  logic        valid, flush;
  logic [31:0] s1, s2;
  logic        stall, busy, done;
  logic [31:0] result;

  mul_seq_ctrl dut (
    .clk_i(clk), .rst_i(rst), .ALUCtrl_i(alu), .valid_i(valid),
    .src1_i(s1), .src2_i(s2), .flush_i(flush),
    .stall_o(stall), .busy_o(busy), .done_o(done), .result_o(result)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t        vt[8];
  int          nchk = 0, nfail = 0;
  int          done_at, t1;
  logic [31:0] last_res;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc_n);
    end
  endtask

  task automatic chk_out(input string nm, input logic st, input logic bz, input logic dn);
    chk({nm, " stall"}, {31'h0, stall}, {31'h0, st});
    chk({nm, " busy"},  {31'h0, busy},  {31'h0, bz});
    chk({nm, " done"},  {31'h0, done},  {31'h0, dn});
  endtask

  // Start cycle T, RUN T+1..T+32, DONE at T+33. Operands are scrambled during RUN.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input bit fl_done);
    step();
    rst = 1'b0; flush = 1'b0; valid = 1'b1; alu = 4'b1000; s1 = a; s2 = b;
    samp();
    chk_out($sformatf("start %0h*%0h", a, b), 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      step();
      valid = 1'b0; alu = 4'b0000; s1 = $urandom; s2 = $urandom;
      samp();
      chk_out($sformatf("run%0d %0h*%0h", i, a, b), 1'b1, 1'b1, 1'b0);
    end
    step();
    if (fl_done) flush = 1'b1;
    samp();
    chk_out($sformatf("done %0h*%0h", a, b), 1'b0, 1'b0, 1'b1);
    chk($sformatf("result %0h*%0h", a, b), result, p);
    done_at  = cyc_n;
    last_res = p;
  endtask

  initial begin
    vt[0] = '{32'd7,        32'd6,        32'd42};
    vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vt[2] = '{32'h00010000, 32'h00010000, 32'h00000000};
    vt[3] = '{32'h0,        32'h12345,    32'h0};
    vt[4] = '{32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE};
    vt[5] = '{32'h80000000, 32'd3,        32'h80000000};
    vt[6] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1};
    vt[7] = '{32'd123,      32'd1000,     32'd123000};

    // A MULT is presented while reset is held, and stall_o must still stay low.
    rst = 1'b1; valid = 1'b1; alu = 4'b1000; flush = 1'b0; s1 = 32'd3; s2 = 32'd3;
    samp();
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    chk("reset result", result, 32'h0);
    step();
    rst = 1'b0; valid = 1'b0;

    // A non-MULT op with valid_i held high for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step(); valid = 1'b1; alu = 4'b0010;
      samp(); chk_out($sformatf("nonmult%0d", i), 1'b0, 1'b0, 1'b0);
    end
    // A MULT opcode without valid_i.
    for (int i = 0; i < 3; i++) begin
      step(); valid = 1'b0; alu = 4'b1000;
      samp(); chk_out($sformatf("novalid%0d", i), 1'b0, 1'b0, 1'b0);
    end
    // A flush in IDLE suppresses the start.
    step(); valid = 1'b1; alu = 4'b1000; flush = 1'b1;
    samp(); chk_out("idle flush", 1'b0, 1'b0, 1'b0);
    step(); valid = 1'b0; flush = 1'b0;
    samp(); chk_out("idle flush next", 1'b0, 1'b0, 1'b0);

    // Table of products. Vector 1 also holds flush_i high during DONE.
    for (int i = 0; i < 8; i++) run_mul(vt[i].a, vt[i].b, vt[i].p, i == 1);

    // Back-to-back MULTs: the two done_o pulses are 34 cycles apart.
    run_mul(32'd2, 32'd3, 32'd6, 1'b0);
    t1 = done_at;
    run_mul(32'd4, 32'd5, 32'd20, 1'b0);
    chk("b2b spacing", done_at - t1, 32'd34);

    // Start 5*9 and flush in the 10th RUN cycle.
    step(); valid = 1'b1; alu = 4'b1000; s1 = 32'd5; s2 = 32'd9;
    samp(); chk_out("flush start", 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(); valid = 1'b0; alu = 4'b0000;
      if (i == 10) flush = 1'b1;
      samp(); chk_out($sformatf("flush run%0d", i), 1'b1, 1'b1, 1'b0);
    end
    step(); flush = 1'b0;
    samp(); chk_out("after flush", 1'b0, 1'b0, 1'b0);
    chk("after flush result", result, last_res);
    for (int i = 0; i < 30; i++) begin
      step(); samp(); chk($sformatf("flush no done %0d", i), {31'h0, done}, 32'h0);
    end

    // Start 7*6, then pulse reset during the 20th RUN cycle.
    step(); valid = 1'b1; alu = 4'b1000; s1 = 32'd7; s2 = 32'd6;
    samp(); chk_out("rst start", 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(); valid = 1'b0; alu = 4'b0000;
      samp(); chk_out($sformatf("rst run%0d", i), 1'b1, 1'b1, 1'b0);
    end
    #2 rst = 1'b1;
    #1;
    chk_out("async reset", 1'b0, 1'b0, 1'b0);
    chk("async reset result", result, 32'h0);
    step(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); samp(); chk_out($sformatf("post rst idle%0d", i), 1'b0, 1'b0, 1'b0);
    end
    run_mul(32'd3, 32'd4, 32'd12, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
